// File: rtl/regfile_write_queue.sv
// Writeback queue in front of the 32-entry register file: buffers requests, drains one per
// cycle as a registered one-hot write enable plus data, and forwards still-pending values.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_addr,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       wb_stall,
  output logic [NREG-1:0]            w_en,
  output logic [WIDTH-1:0]           w_data,
  input  logic [4:0]                 fwd_addr,
  output logic                       fwd_hit,
  output logic [WIDTH-1:0]           fwd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [NREG-1:0]  w_en_q, w_en_d;
  logic [WIDTH-1:0] w_data_q, w_data_d;

  logic             push;
  logic             store;
  logic             pop;
  logic [PW-1:0]    fwd_idx;
  logic             fwd_match;
  logic             out_match;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == {CW{1'b0}});
  assign in_ready = !full && !clr;
  assign count    = count_q;
  assign w_en     = w_en_q;
  assign w_data   = w_data_q;

  // Handshake decode and next-state for pointers, occupancy and the output stage.
  always_comb begin
    push     = in_valid && in_ready;
    store    = push && (in_addr != 5'd0);
    pop      = !empty && !wb_stall;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    w_en_d   = {NREG{1'b0}};
    w_data_d = w_data_q;
    if (clr) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
      w_data_d = {WIDTH{1'b0}};
    end else begin
      wr_ptr_d = store ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_d = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      w_en_d   = pop ? ({{(NREG-1){1'b0}}, 1'b1} << addr_q[rd_ptr_q]) : {NREG{1'b0}};
      w_data_d = pop ? data_q[rd_ptr_q] : w_data_q;
      case ({store, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and output-stage registers.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    w_en_q   <= w_en_d;
    w_data_q <= w_data_d;
  end

  // Entry storage; clr only needs to reset the pointers, so the payload is not cleared.
  always_ff @(posedge clk) begin
    if (!clr && store) begin
      addr_q[wr_ptr_q] <= in_addr;
      data_q[wr_ptr_q] <= in_data;
    end
  end

  // Forwarding: output stage is oldest, then queue entries oldest to newest, so later matches win.
  always_comb begin
    out_match = (fwd_addr != 5'd0) && w_en_q[fwd_addr];
    fwd_hit   = out_match;
    fwd_data  = out_match ? w_data_q : {WIDTH{1'b0}};
    fwd_idx   = rd_ptr_q;
    fwd_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx   = rd_ptr_q + PW'(i);
      fwd_match = (fwd_addr != 5'd0) && (CW'(i) < count_q) && (addr_q[fwd_idx] == fwd_addr);
      fwd_hit   = fwd_hit | fwd_match;
      fwd_data  = fwd_match ? data_q[fwd_idx] : fwd_data;
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: a vector table for the main flow plus
// hand-written sequences for stall/full, forwarding order, clear and wrap-around.
module tb_regfile_write_queue;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        wb_stall;
  logic [31:0] w_en;
  logic [31:0] w_data;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_write_queue #(.DEPTH(4), .WIDTH(32), .NREG(32)) dut (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_stall(wb_stall), .w_en(w_en), .w_data(w_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        st;
    logic [4:0]  fa;
    logic [31:0] e_wen;
    logic [31:0] e_wdata;
    logic [2:0]  e_cnt;
    logic        e_hit;
    logic [31:0] e_fdata;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] ea [5];
    logic        acc;

    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 32'h0,   32'h0,        3'd1, 1'b1, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'h20,  32'hDEADBEEF, 3'd0, 1'b1, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 32'h0,   32'hDEADBEEF, 3'd0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,   32'hDEADBEEF, 3'd0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd3, 32'h0,   32'hDEADBEEF, 3'd1, 1'b1, 32'h33};
    tbl[5]  = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd3, 32'h0,   32'hDEADBEEF, 3'd2, 1'b1, 32'h33};
    tbl[6]  = '{1'b1, 5'd3, 32'h3B,       1'b1, 5'd3, 32'h0,   32'hDEADBEEF, 3'd3, 1'b1, 32'h3B};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 32'h8,   32'h33,       3'd2, 1'b1, 32'h3B};
    tbl[8]  = '{1'b1, 5'd9, 32'h9C,       1'b0, 5'd9, 32'h200, 32'h99,       3'd2, 1'b1, 32'h9C};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 32'h8,   32'h3B,       3'd1, 1'b1, 32'h9C};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 32'h200, 32'h9C,       3'd0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 32'h0,   32'h9C,       3'd0, 1'b0, 32'h0};

    clr = 1'b1; in_valid = 1'b0; in_addr = 5'd0; in_data = 32'h0; wb_stall = 1'b0; fwd_addr = 5'd0;
    #1;
    chk("in_ready_during_clr", in_ready, 1'b0);
    tick();
    clr = 1'b0;
    #1;
    chk("rst_w_en", w_en, 32'h0);
    chk("rst_w_data", w_data, 32'h0);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);

    // Main table: inputs applied before one edge, outputs checked after it.
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v; in_addr = tbl[i].a; in_data = tbl[i].d;
      wb_stall = tbl[i].st; fwd_addr = tbl[i].fa;
      tick();
      chk($sformatf("v%0d_w_en", i), w_en, tbl[i].e_wen);
      chk($sformatf("v%0d_w_data", i), w_data, tbl[i].e_wdata);
      chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("v%0d_empty", i), empty, tbl[i].e_cnt == 3'd0);
      chk($sformatf("v%0d_full", i), full, tbl[i].e_cnt == 3'd4);
      chk($sformatf("v%0d_fwd_hit", i), fwd_hit, tbl[i].e_hit);
      chk($sformatf("v%0d_fwd_data", i), fwd_data, tbl[i].e_fdata);
    end
    in_valid = 1'b0;

    // Fill while stalled, hold a fifth request, then drain in order.
    wb_stall = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_addr = 5'(k); in_data = 32'(k * 32'h11);
      tick();
    end
    chk("full_count", count, 3'd4);
    chk("full_flag", full, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    in_addr = 5'd6; in_data = 32'h66;
    tick();
    chk("full_held_count", count, 3'd4);
    ea[0] = 32'h2; ea[1] = 32'h4; ea[2] = 32'h8; ea[3] = 32'h10; ea[4] = 32'h40;
    wb_stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      chk($sformatf("drain%0d_w_en", k), w_en, ea[k]);
      if (k == 0) chk("full_pop_no_push_count", count, 3'd3);
    end
    chk("drain_last_data", w_data, 32'h66);
    tick();
    chk("drain_idle_w_en", w_en, 32'h0);

    // Two pending writes to r7: youngest wins, hit persists through output stage.
    wb_stall = 1'b1; in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    in_valid = 1'b0; fwd_addr = 5'd7;
    #1;
    chk("fwd7_hit", fwd_hit, 1'b1);
    chk("fwd7_data", fwd_data, 32'hB);
    wb_stall = 1'b0;
    tick();
    tick();
    chk("fwd7_out_hit", fwd_hit, 1'b1);
    chk("fwd7_out_data", fwd_data, 32'hB);
    tick();
    chk("fwd7_gone_hit", fwd_hit, 1'b0);
    chk("fwd7_gone_data", fwd_data, 32'h0);

    // Clear with three entries queued: nothing may drain afterwards.
    wb_stall = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_addr = 5'(10 + k); in_data = 32'(32'h100 + k);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_clr_count", count, 3'd3);
    clr = 1'b1;
    #1;
    chk("clr_in_ready", in_ready, 1'b0);
    tick();
    clr = 1'b0;
    #1;
    chk("clr_count", count, 3'd0);
    chk("clr_empty", empty, 1'b1);
    chk("clr_w_en", w_en, 32'h0);
    wb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post_clr%0d_w_en", k), w_en, 32'h0);
    end

    // Back-to-back pushes with no stall: pointers wrap, order preserved.
    for (int j = 0; j <= 10; j++) begin
      if (j < 10) begin
        in_valid = 1'b1; in_addr = 5'(j + 1); in_data = 32'(j * 32'h101);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk($sformatf("stream%0d_count_le1", j), count <= 3'd1, 1'b1);
      if (j == 0) begin
        chk("stream0_w_en", w_en, 32'h0);
      end else begin
        chk($sformatf("stream%0d_w_en", j), w_en, 32'd1 << j);
        chk($sformatf("stream%0d_w_data", j), w_data, 32'((j - 1) * 32'h101));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Buffers register-file writeback requests and drains them, one per cycle, into the 32-entry register file as a one-hot write-enable vector plus a shared data bus. It is the write-side counterpart of the register file's enabled-write / tristate-read storage cells. It sits between the processor writeback stage and the register array. It also provides a forwarding lookup so readers see values that are still queued.

## Interface
- DEPTH, 4, queue entries (power of two, 2..8)
- WIDTH, 32, data width
- NREG, 32, number of registers; address width is 5

- clk  in  1  rising-edge clock
- clr  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  writeback request present
- in_ready  out  1  queue can accept; = !full && !clr
- in_addr  in  5  destination register
- in_data  in  WIDTH  write data
- wb_stall  in  1  register file write port unavailable this cycle; hold head
- w_en  out  NREG  one-hot write enable to register array, registered
- w_data  out  WIDTH  data for asserted w_en bit, registered
- fwd_addr  in  5  read address to check against pending writes
- fwd_hit  out  1  fwd_addr has a pending write (combinational)
- fwd_data  out  WIDTH  youngest pending data for fwd_addr; 0 when !fwd_hit
- count  out  log2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits wide and wrapping modulo DEPTH. count is tracked explicitly.
- Push: in_valid && in_ready at an edge.
  - in_addr != 0: write the entry at wr_ptr and advance wr_ptr.
  - in_addr == 0: the handshake completes but nothing is stored (r0 is hardwired zero).
- Pop: !empty && !wb_stall at an edge.
  - Registers w_en <= 1 << head.addr and w_data <= head.data.
  - Advances rd_ptr.
- When no pop occurs at an edge, w_en <= 0 and w_data holds its previous value.
- Simultaneous push and pop: both occur and count is unchanged.
- When full, a pop in the same cycle does not open a slot for that cycle's push; in_ready stays low.
- At most one w_en bit is ever set. Bit 0 is never set.
- Forwarding checks the queue entries and the output stage (w_en/w_data, since the array commits at the end of that cycle).
  - Age order for matches, youngest first: newest queue entry, then oldest queue entry, then the output stage.
  - fwd_addr == 0: fwd_hit = 0.
- Writes to the same register stay in acceptance order, so the last write wins in the array.

## Timing
- Reset, at the edge where clr = 1:
  - wr_ptr = rd_ptr = 0, count = 0.
  - w_en = 0, w_data = 0.
  - empty = 1, full = 0.
- in_ready = 0 throughout the clr cycle.
- Reset during operation discards all queued entries and any pending output. No w_en pulse follows the reset edge.
- Latency with wb_stall = 0 and an empty queue:
  - Request accepted at edge k.
  - w_en is high during cycle k+1 to k+2.
  - The register array captures the value at edge k+2.
- Throughput: one write per cycle sustained.
- wb_stall holds the head entry. The stall takes effect at the same edge it is sampled.
- Forwarding is combinational with no added cycle. The result reflects state after the most recent edge and excludes the current-cycle in_* request.

## Test plan
- Reset, then push addr 5 / 0xDEADBEEF at edge 1:
  - w_en == 32'h0000_0020 and w_data == 0xDEADBEEF after edge 2.
  - w_en == 0 after edge 3.
- wb_stall = 1, push addr 1..4 (data 0x11..0x44):
  - full = 1, in_ready = 0, count = 4.
  - Fifth request is held.
  - Release the stall: w_en bits 1, 2, 3, 4 fire on 4 consecutive cycles, then the held request follows.
- Stalled queue holding addr 7 = 0xA, then addr 7 = 0xB, with fwd_addr = 7:
  - fwd_hit = 1, fwd_data = 0xB.
  - After both drain and one more cycle: fwd_hit = 0.
- Push addr 0 / 0xFFFF:
  - in_ready handshake completes, count stays 0, w_en stays 0.
  - fwd_addr = 0 gives fwd_hit = 0.
- Queue at count = 3 (stalled), assert clr for one cycle:
  - count = 0, empty = 1.
  - No w_en pulse in the next 4 cycles with the stall released.
- Continuous push each cycle over 10 cycles with wb_stall = 0, wr_ptr wrapping twice:
  - count never exceeds 1.
  - w_en sequence matches the input order exactly.
